// File: rtl/snap_ctrl_pkg.sv
// Shared types and constants for the snapshot capture controller.
package snap_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    CAPTURE,
    DONE
  } state_t;

  // Bit positions inside the software control word
  localparam int unsigned CTRL_ARM     = 0;
  localparam int unsigned CTRL_TRIGSEL = 1;
  localparam int unsigned CTRL_CIRC    = 2;
  localparam int unsigned CTRL_STOP    = 3;

  // Bit position of the done flag inside the status word
  localparam int unsigned STAT_DONE = 31;

endpackage

// File: rtl/snap_capture_ctrl_if.sv
// BRAM write port between the capture controller and the snapshot memory.
interface snap_capture_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) ();

  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;

  modport master (output bram_addr, output bram_data, output bram_we);
  modport slave  (input  bram_addr, input  bram_data, input  bram_we);

endinterface

// File: rtl/snap_trig_offset.sv
// Post-trigger offset counter: loaded on the trigger, counts down on valid samples.
module snap_trig_offset #(
  parameter int unsigned OFFSET_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [OFFSET_W-1:0] load_val,
  input  logic                dec,
  output logic                expired
);

  logic [OFFSET_W-1:0] off_cnt;

  // Load takes priority; the counter parks at zero so expiry stays asserted
  always_ff @(posedge clk) begin
    if (rst) begin
      off_cnt <= '0;
    end else if (load) begin
      off_cnt <= load_val;
    end else if (dec && (off_cnt != '0)) begin
      off_cnt <= off_cnt - OFFSET_W'(1);
    end
  end

  assign expired = (off_cnt == '0);

endmodule

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture sequencer: arm, trigger qualification, post-trigger offset,
// one-shot or circular BRAM write addressing and completion reporting.
module snap_capture_ctrl
  import snap_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned OFFSET_W = 32
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic [31:0]         ctrl,
  input  logic [OFFSET_W-1:0] trig_offset,
  input  logic [DATA_W-1:0]   din,
  input  logic                din_valid,
  input  logic                trig,
  snap_capture_ctrl_if.master bram,
  output logic [31:0]         tr_en_cnt,
  output logic [31:0]         status,
  output logic                busy
);

  state_t            state;
  logic              arm_q;
  logic              stop_q;
  logic              circ_q;
  logic              done;
  logic [ADDR_W-1:0] wr_ptr;

  logic arm_edge;
  logic stop_edge;
  logic hit;
  logic off_load;
  logic off_dec;
  logic off_expired;
  logic write_now;

  // Upper control bits are reserved
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl[31:4];

  assign arm_edge  = ctrl[CTRL_ARM] & ~arm_q;
  assign stop_edge = ctrl[CTRL_STOP] & ~stop_q;
  assign hit       = din_valid & (ctrl[CTRL_TRIGSEL] ? trig : 1'b1);

  // A new arm edge overrides any offset or write activity in the same cycle
  assign off_load = ~arm_edge & (state == ARMED) & hit & (trig_offset != '0);
  assign off_dec  = ~arm_edge & (state == DELAY) & din_valid;

  assign write_now = ~arm_edge & din_valid &
                     (((state == ARMED) & hit & (trig_offset == '0)) |
                      ((state == DELAY) & off_expired) |
                      (state == CAPTURE));

  snap_trig_offset #(
    .OFFSET_W (OFFSET_W)
  ) u_trig_offset (
    .clk      (user_clk),
    .rst      (user_rst),
    .load     (off_load),
    .load_val (trig_offset - OFFSET_W'(1)),
    .dec      (off_dec),
    .expired  (off_expired)
  );

  // Capture FSM with registered BRAM write port and counters
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state          <= IDLE;
      arm_q          <= 1'b0;
      stop_q         <= 1'b0;
      circ_q         <= 1'b0;
      done           <= 1'b0;
      wr_ptr         <= '0;
      tr_en_cnt      <= '0;
      bram.bram_addr <= '0;
      bram.bram_data <= '0;
      bram.bram_we   <= 1'b0;
    end else begin
      arm_q        <= ctrl[CTRL_ARM];
      stop_q       <= ctrl[CTRL_STOP];
      bram.bram_we <= write_now;

      if (write_now) begin
        bram.bram_addr <= wr_ptr;
        bram.bram_data <= din;
        wr_ptr         <= wr_ptr + ADDR_W'(1);
        if (tr_en_cnt != '1) begin
          tr_en_cnt <= tr_en_cnt + 32'd1;
        end
      end

      if (arm_edge) begin
        state     <= ARMED;
        wr_ptr    <= '0;
        tr_en_cnt <= '0;
        done      <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ARMED: begin
            if (hit) begin
              circ_q <= ctrl[CTRL_CIRC];
              state  <= (trig_offset == '0) ? CAPTURE : DELAY;
            end
          end
          DELAY: begin
            if (din_valid && off_expired) begin
              state <= CAPTURE;
            end
          end
          CAPTURE: begin
            // One-shot ends after the top address; stop ends after this cycle's write
            if (stop_edge || (!circ_q && din_valid && (wr_ptr == '1))) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign status = {done, {(STAT_DONE - ADDR_W){1'b0}}, wr_ptr};
  assign busy   = (state == ARMED) || (state == DELAY) || (state == CAPTURE);

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Self-checking bench for snap_capture_ctrl with a list-based capture model.
module tb_snap_capture_ctrl;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OFFSET_W = 32;
  localparam int          DEPTH    = 16;
  localparam int          NO_LIMIT = 32'h3fff_ffff;

  typedef struct packed {
    logic [31:0] data;
    int          cyc;
    logic        trig;
    logic        valid;
  } samp_t;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic                user_clk = 1'b0;
  logic                user_rst;
  logic [31:0]         ctrl;
  logic [OFFSET_W-1:0] trig_offset;
  logic [DATA_W-1:0]   din;
  logic                din_valid;
  logic                trig;
  logic [31:0]         tr_en_cnt;
  logic [31:0]         status;
  logic                busy;

  logic c_arm, c_tsel, c_circ, c_stop;
  assign ctrl = {28'd0, c_stop, c_circ, c_tsel, c_arm};

  snap_capture_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bram_bus ();

  snap_capture_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .OFFSET_W (OFFSET_W)
  ) dut (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .ctrl        (ctrl),
    .trig_offset (trig_offset),
    .din         (din),
    .din_valid   (din_valid),
    .trig        (trig),
    .bram        (bram_bus),
    .tr_en_cnt   (tr_en_cnt),
    .status      (status),
    .busy        (busy)
  );

  always #5 user_clk = ~user_clk;

  int    n_asserts = 0;
  int    n_fail    = 0;
  int    cyc       = 0;
  int    arm_cyc   = 0;
  samp_t log_q[$];
  wr_t   got[$];
  wr_t   exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: log the presented sample, then record any write visible after the edge
  task automatic tick();
    samp_t s;
    wr_t   w;
    s.data  = din;
    s.cyc   = cyc;
    s.trig  = trig;
    s.valid = din_valid;
    log_q.push_back(s);
    @(posedge user_clk);
    #1;
    cyc++;
    if (bram_bus.bram_we === 1'b1) begin
      w.addr = bram_bus.bram_addr;
      w.data = bram_bus.bram_data;
      w.cyc  = cyc;
      got.push_back(w);
    end
  endtask

  task automatic sample(input logic v, input logic [31:0] d, input logic t);
    din_valid = v;
    din       = d;
    trig      = t;
    tick();
  endtask

  task automatic do_arm(input logic hold);
    c_arm = 1'b0;
    sample(1'b0, 32'd0, 1'b0);
    c_arm   = 1'b1;
    arm_cyc = cyc;
    sample(1'b0, 32'd0, 1'b0);
    c_arm = hold;
    got.delete();
  endtask

  // Expected writes from the sample log: the first qualifying valid sample after arm
  // is index 0; samples from index off onward are stored at consecutive addresses.
  task automatic build_model(input int a_cyc, input int l_cyc, input bit tsel, input int off,
                             input bit circ);
    samp_t v[$];
    wr_t   w;
    int    h;
    int    lim;
    h = -1;
    exp_q.delete();
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].valid && log_q[i].cyc > a_cyc && log_q[i].cyc <= l_cyc) v.push_back(log_q[i]);
    end
    for (int i = 0; i < v.size(); i++) begin
      if (h < 0 && (!tsel || v[i].trig)) h = i;
    end
    lim = circ ? NO_LIMIT : DEPTH;
    if (h >= 0) begin
      for (int k = 0; (h + off + k < v.size()) && (k < lim); k++) begin
        w.addr = 4'(k % DEPTH);
        w.data = v[h + off + k].data;
        w.cyc  = v[h + off + k].cyc + 1;
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    chk($sformatf("%s write count", tag), 64'(got.size()), 64'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), 64'(got[i].addr), 64'(exp_q[i].addr));
      chk($sformatf("%s data[%0d]", tag, i), 64'(got[i].data), 64'(exp_q[i].data));
      chk($sformatf("%s cycle[%0d]", tag, i), 64'(got[i].cyc), 64'(exp_q[i].cyc));
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk($sformatf("%s bram_addr", tag), 64'(bram_bus.bram_addr), 64'd0);
    chk($sformatf("%s bram_data", tag), 64'(bram_bus.bram_data), 64'd0);
    chk($sformatf("%s bram_we", tag), 64'(bram_bus.bram_we), 64'd0);
    chk($sformatf("%s tr_en_cnt", tag), 64'(tr_en_cnt), 64'd0);
    chk($sformatf("%s status", tag), 64'(status), 64'd0);
    chk($sformatf("%s busy", tag), 64'(busy), 64'd0);
  endtask

  initial begin
    int    stop_cyc;
    int    rearm_cyc;
    int    off;
    int    n;
    bit    e_done;
    logic  v;
    c_arm = 0; c_tsel = 0; c_circ = 0; c_stop = 0;
    trig_offset = '0; din = '0; din_valid = 0; trig = 0;

    // Reset state
    user_rst = 1'b1;
    tick();
    tick();
    user_rst = 1'b0;
    chk_outputs_zero("reset");

    // Immediate one-shot, offset 0
    do_arm(1'b0);
    chk("armed busy", 64'(busy), 64'd1);
    for (int i = 0; i <= 20; i++) sample(1'b1, 32'(i), 1'b0);
    sample(1'b0, 32'd0, 1'b0);
    build_model(arm_cyc, NO_LIMIT, 1'b0, 0, 1'b0);
    compare_writes("oneshot");
    chk("oneshot writes", 64'(got.size()), 64'd16);
    chk("oneshot tr_en_cnt", 64'(tr_en_cnt), 64'd16);
    chk("oneshot status", 64'(status), 64'h8000_0000);
    chk("oneshot busy", 64'(busy), 64'd0);

    // External trigger with offset 3, valid every other cycle
    c_tsel = 1'b1;
    trig_offset = 32'd3;
    do_arm(1'b0);
    sample(1'b0, 32'd77, 1'b1);
    sample(1'b0, 32'd78, 1'b1);
    for (int d = 90; d <= 130; d++) begin
      sample(1'b1, 32'(d), (d == 100));
      sample(1'b0, 32'hdead_0000 + 32'(d), (d == 95));
    end
    build_model(arm_cyc, NO_LIMIT, 1'b1, 3, 1'b0);
    compare_writes("exttrig");
    if (got.size() > 0) begin
      chk("exttrig first data", 64'(got[0].data), 64'd103);
      chk("exttrig first addr", 64'(got[0].addr), 64'd0);
    end else begin
      chk("exttrig first write present", 64'd0, 64'd1);
    end
    chk("exttrig status", 64'(status), 64'h8000_0000);

    // Circular with stop after 20 writes
    c_tsel = 1'b0;
    c_circ = 1'b1;
    trig_offset = 32'd0;
    do_arm(1'b0);
    stop_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 19) begin
        c_stop   = 1'b1;
        stop_cyc = cyc;
      end
      sample(1'b1, 32'd200 + 32'(i), 1'b0);
    end
    for (int i = 0; i < 5; i++) sample(1'b1, 32'd300 + 32'(i), 1'b0);
    c_stop = 1'b0;
    sample(1'b0, 32'd0, 1'b0);
    build_model(arm_cyc, stop_cyc, 1'b0, 0, 1'b1);
    compare_writes("circ");
    chk("circ tr_en_cnt", 64'(tr_en_cnt), 64'd20);
    chk("circ status", 64'(status), 64'h8000_0004);
    chk("circ busy", 64'(busy), 64'd0);

    // Re-arm during capture after 5 writes
    c_circ = 1'b0;
    do_arm(1'b0);
    for (int i = 0; i < 5; i++) sample(1'b1, 32'd400 + 32'(i), 1'b0);
    c_arm     = 1'b1;
    rearm_cyc = cyc;
    sample(1'b1, 32'd405, 1'b0);
    c_arm = 1'b0;
    chk("rearm bram_we", 64'(bram_bus.bram_we), 64'd0);
    chk("rearm tr_en_cnt", 64'(tr_en_cnt), 64'd0);
    chk("rearm busy", 64'(busy), 64'd1);
    chk("rearm status", 64'(status), 64'd0);
    build_model(arm_cyc, rearm_cyc - 1, 1'b0, 0, 1'b0);
    compare_writes("pre-rearm");
    got.delete();
    for (int i = 0; i < 18; i++) sample(1'b1, 32'd500 + 32'(i), 1'b0);
    sample(1'b0, 32'd0, 1'b0);
    build_model(rearm_cyc, NO_LIMIT, 1'b0, 0, 1'b0);
    compare_writes("post-rearm");

    // Reset while counting down the offset
    trig_offset = 32'd5;
    do_arm(1'b0);
    for (int i = 0; i < 3; i++) sample(1'b1, 32'd600 + 32'(i), 1'b0);
    chk("delay busy", 64'(busy), 64'd1);
    user_rst = 1'b1;
    sample(1'b1, 32'd603, 1'b0);
    user_rst = 1'b0;
    chk_outputs_zero("midreset");
    for (int i = 0; i < 10; i++) sample(1'b1, 32'd610 + 32'(i), 1'b0);
    chk("midreset writes", 64'(got.size()), 64'd0);
    chk("midreset busy", 64'(busy), 64'd0);

    // Stop in IDLE and ARMED ignored; held arm after DONE does not re-arm
    trig_offset = 32'd0;
    c_stop = 1'b1;
    sample(1'b1, 32'd700, 1'b0);
    c_stop = 1'b0;
    sample(1'b1, 32'd701, 1'b0);
    chk("idle stop busy", 64'(busy), 64'd0);
    chk("idle stop writes", 64'(got.size()), 64'd0);
    c_tsel = 1'b1;
    do_arm(1'b1);
    c_stop = 1'b1;
    sample(1'b1, 32'd710, 1'b0);
    c_stop = 1'b0;
    chk("armed stop busy", 64'(busy), 64'd1);
    for (int i = 0; i < 20; i++) sample(1'b1, 32'd720 + 32'(i), (i == 0));
    for (int i = 0; i < 10; i++) sample(1'b1, 32'd800 + 32'(i), 1'b1);
    build_model(arm_cyc, NO_LIMIT, 1'b1, 0, 1'b0);
    compare_writes("heldarm");
    chk("heldarm tr_en_cnt", 64'(tr_en_cnt), 64'd16);
    chk("heldarm status", 64'(status), 64'h8000_0000);
    chk("heldarm busy", 64'(busy), 64'd0);
    c_arm = 1'b0;

    // Randomized captures
    for (int it = 0; it < 8; it++) begin
      c_tsel      = 1'($urandom_range(0, 1));
      c_circ      = 1'($urandom_range(0, 1));
      off         = int'($urandom_range(0, 4));
      trig_offset = 32'(off);
      do_arm(1'b0);
      for (int i = 0; i < 80; i++) begin
        v = 1'($urandom_range(0, 1));
        sample(v, $urandom, ($urandom_range(0, 3) == 0));
      end
      sample(1'b0, 32'd0, 1'b0);
      build_model(arm_cyc, NO_LIMIT, c_tsel, off, c_circ);
      compare_writes($sformatf("rand%0d", it));
      n      = exp_q.size();
      e_done = !c_circ && (n == DEPTH);
      chk($sformatf("rand%0d tr_en_cnt", it), 64'(tr_en_cnt), 64'(n));
      chk($sformatf("rand%0d status", it), 64'(status), 64'({e_done, 27'd0, 4'(n % DEPTH)}));
      chk($sformatf("rand%0d busy", it), 64'(busy), 64'(!e_done));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/snap_capture_ctrl.md
Name: snap_capture_ctrl

Overview:
Sequences one ADC snapshot capture: arm, trigger qualification, post-trigger offset, BRAM write addressing, one-shot or circular capture, and completion. Runs in the user (ADC) clock domain between the ppc2simulink control register and the snapshot BRAM. Its trigger-enabled write count drives the simulink2ppc status register read by software as tr_en_cnt. A second status word reports done flag plus write pointer.

Parameters:
ADDR_W, 10, BRAM address width; capture depth = 2^ADDR_W samples
DATA_W, 32, sample width
OFFSET_W, 32, width of post-trigger offset value

Ports:
user_clk  in  1  user-domain clock, all logic rising-edge
user_rst  in  1  synchronous active-high reset
ctrl  in  32  control word from software: [0] arm, [1] trig_sel (0=immediate, 1=external), [2] circ, [3] stop
trig_offset  in  OFFSET_W  valid samples skipped after trigger before first write
din  in  DATA_W  sample data
din_valid  in  1  sample qualifier
trig  in  1  external trigger, sampled only when din_valid=1
bram_addr  out  ADDR_W  BRAM write address
bram_data  out  DATA_W  BRAM write data
bram_we  out  1  BRAM write enable
tr_en_cnt  out  32  samples written since last arm, to simulink2ppc register
status  out  32  {done, 31-ADDR_W zeros, wr_ptr}
busy  out  1  high in ARMED, DELAY, CAPTURE

Behaviour:
- Reset (user_rst=1 at clock edge): state IDLE; bram_addr=0, bram_data=0, bram_we=0, tr_en_cnt=0, status=0, busy=0, wr_ptr=0, edge-detect registers=0.
- Edge detection: arm_edge = ctrl[0] & ~ctrl_q[0]; stop_edge = ctrl[3] & ~ctrl_q[3]. ctrl_q is registered each cycle.
- arm_edge in any state takes priority over everything else. Next state ARMED; wr_ptr=0, tr_en_cnt=0, done=0, bram_we=0 that cycle.
- Trigger event (hit) = din_valid & (trig_sel ? trig : 1). trig without din_valid is ignored.
- States:
  - IDLE: wait for arm_edge.
  - ARMED: on hit, sample index 0 = trigger sample.
    - trig_offset==0: trigger sample is written this cycle; go CAPTURE.
    - Otherwise: load off_cnt = trig_offset-1 and go DELAY; trigger sample is not written.
  - DELAY: on each din_valid, if off_cnt==0 write that sample and go CAPTURE; else decrement off_cnt. First written sample is index trig_offset.
  - CAPTURE: each din_valid writes din at wr_ptr, then wr_ptr++ (mod 2^ADDR_W) and tr_en_cnt++.
    - One-shot (circ=0): after writing address 2^ADDR_W-1, go DONE. Exactly 2^ADDR_W writes occur.
    - Circular (circ=1): wr_ptr wraps to 0 and capture continues. stop_edge goes to DONE after the write, if any, of the same cycle.
  - DONE: done=1, bram_we=0; hold until arm_edge.
- stop_edge outside CAPTURE is ignored. trig_sel, circ and trig_offset are sampled on the hit cycle and held internally until the next arm.
- Write timing: bram_addr/bram_data/bram_we are registered, asserted 1 cycle after the qualifying din_valid cycle, 1-cycle pulse per sample. tr_en_cnt and wr_ptr update in the same cycle as bram_we.
- tr_en_cnt saturates at 0xFFFFFFFF in circular mode; no wrap.
- status[31]=done; status[ADDR_W-1:0]=wr_ptr. In circular mode this is the oldest sample address. status is registered.
- Reset mid-capture: abandon immediately; no further writes.

Decomposition:
- Package snap_ctrl_pkg holds:
  - state enum {IDLE, ARMED, DELAY, CAPTURE, DONE}
  - ctrl bit-index constants CTRL_ARM=0, CTRL_TRIGSEL=1, CTRL_CIRC=2, CTRL_STOP=3
  - status bit constant STAT_DONE=31
- One sub-module, snap_trig_offset: off_cnt load/decrement, reports expiry. Top level holds FSM, addressing and counters.

Test Plan:
- Immediate one-shot, ADDR_W=4, offset 0: arm pulse, din_valid every cycle with din=0..20 -> exactly 16 bram_we pulses, addr 0..15 with data 0..15; done=1; tr_en_cnt=16; status=0x80000000.
- External trigger with offset 3: trig on sample 100, din_valid every other cycle -> first write is data 103 at addr 0; trig asserted with din_valid=0 beforehand is ignored.
- Circular, ADDR_W=4: stop after 20 writes -> addr sequence 0..15,0..3; tr_en_cnt=20; status=0x80000004.
- Re-arm during CAPTURE after 5 writes -> bram_we drops the next cycle; tr_en_cnt=0; state ARMED; next capture starts at addr 0.
- user_rst asserted in DELAY -> all outputs 0 the following cycle; no write occurs when the offset would have expired.
- stop asserted in IDLE/ARMED, and ctrl[0] held high with no new edge after DONE -> no state change; no writes.
